// File: rtl/uart_rx_hex_parser_pkg.sv
// Shared constants, parser state encoding and ASCII/hex conversion helpers
// used by both the receive parser and the transmit-side formatter.
package uart_rx_hex_parser_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        DISCARD = 2'b10
    } parse_state_t;

    // Returns {is_hex, nibble}; upper and lower case letters decode identically.
    function automatic logic [4:0] ascii_to_nibble(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c >= 8'h30 && c <= 8'h39)
            r = {1'b1, c[3:0]};
        else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
            r = {1'b1, c[3:0] + 4'd9};
        return r;
    endfunction

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART byte receiver: 8N1, LSB first, mid-bit sampling of a synchronised line.
module uart_rx #(
    parameter int CLK_FRE   = 50,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready,
    input  logic       rx_pin
);
    localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
    localparam int CW    = $clog2(CYCLE + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_t;

    rx_state_t       state, state_next;
    logic            rx_d0, rx_d1;
    logic [CW-1:0]   cyc_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            sample_pt;

    // Start bit is checked at its midpoint; every later bit one full period on.
    assign sample_pt = (state == S_START) ? (cyc_cnt == CW'(CYCLE / 2 - 1))
                                          : (cyc_cnt == CW'(CYCLE - 1));

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (!rx_d1) state_next = S_START;
            S_START: if (sample_pt) state_next = rx_d1 ? S_IDLE : S_DATA;
            S_DATA:  if (sample_pt && bit_cnt == 3'd7) state_next = S_STOP;
            S_STOP:  if (sample_pt) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_d0         <= 1'b1;
            rx_d1         <= 1'b1;
            state         <= S_IDLE;
            cyc_cnt       <= '0;
            bit_cnt       <= '0;
            shift         <= '0;
            rx_data       <= '0;
            rx_data_valid <= 1'b0;
        end else begin
            rx_d0 <= rx_pin;
            rx_d1 <= rx_d0;
            state <= state_next;
            if (state == S_IDLE || sample_pt)
                cyc_cnt <= '0;
            else
                cyc_cnt <= cyc_cnt + 1'b1;
            if (state == S_START)
                bit_cnt <= '0;
            else if (state == S_DATA && sample_pt) begin
                shift   <= {rx_d1, shift[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state == S_STOP && sample_pt && rx_d1) begin
                rx_data       <= shift;
                rx_data_valid <= 1'b1;
            end else if (rx_data_valid && rx_data_ready) begin
                rx_data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_rx_hex_parser.sv
// Parses CR/LF-terminated fixed-length ASCII hex words from the UART line
// into a 4*DIGITS-bit value, with a one-cycle valid or error strobe per word.
module uart_rx_hex_parser
    import uart_rx_hex_parser_pkg::*;
#(
    parameter int CLK_FRE     = 100,
    parameter int BAUD_RATE   = 115200,
    parameter int DIGITS      = 5,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  uart_rx,
    output logic [4*DIGITS-1:0]   rx_data_out,
    output logic                  rx_pulse,
    output logic                  rx_err
);
    localparam int W     = 4 * DIGITS;
    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 2);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0] TO_MAX  = '1;

    logic [7:0]      byte_data;
    logic            byte_valid;
    logic [4:0]      dec;
    logic            is_hex, is_term, timeout_hit;

    parse_state_t    state, state_next;
    logic [W-1:0]    shift, shift_next, data_next;
    logic [CNT_W-1:0] count, count_next;
    logic [TO_W-1:0] to_cnt;
    logic            pulse_next, err_next;

    uart_rx #(
        .CLK_FRE   (CLK_FRE),
        .BAUD_RATE (BAUD_RATE)
    ) u_uart_rx (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data       (byte_data),
        .rx_data_valid (byte_valid),
        .rx_data_ready (1'b1),
        .rx_pin        (uart_rx)
    );

    assign dec     = ascii_to_nibble(byte_data);
    assign is_hex  = dec[4];
    assign is_term = (byte_data == ASCII_CR) || (byte_data == ASCII_LF);
    assign timeout_hit = (TIMEOUT_CYC != 0) && (state == COLLECT) &&
                         !byte_valid && (to_cnt >= TO_LAST);

    always_comb begin
        state_next = state;
        shift_next = shift;
        count_next = count;
        data_next  = rx_data_out;
        pulse_next = 1'b0;
        err_next   = 1'b0;
        if (byte_valid) begin
            case (state)
                IDLE: begin
                    if (is_hex) begin
                        shift_next = W'(dec[3:0]);
                        count_next = CNT_W'(1);
                        state_next = COLLECT;
                    end else if (!is_term) begin
                        err_next   = 1'b1;
                        state_next = DISCARD;
                    end
                end
                COLLECT: begin
                    if (is_hex) begin
                        if (count == CNT_W'(DIGITS)) begin
                            err_next   = 1'b1;
                            state_next = DISCARD;
                        end else begin
                            shift_next = W'({shift, dec[3:0]});
                            count_next = count + 1'b1;
                        end
                    end else if (is_term) begin
                        if (count == CNT_W'(DIGITS)) begin
                            data_next  = shift;
                            pulse_next = 1'b1;
                        end else begin
                            err_next   = 1'b1;
                        end
                        state_next = IDLE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = DISCARD;
                    end
                end
                DISCARD: if (is_term) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end else if (timeout_hit) begin
            err_next   = 1'b1;
            state_next = IDLE;
        end
        // A partial word only survives while collecting.
        if (state_next != COLLECT) begin
            shift_next = '0;
            count_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shift       <= '0;
            count       <= '0;
            to_cnt      <= '0;
            rx_data_out <= '0;
            rx_pulse    <= 1'b0;
            rx_err      <= 1'b0;
        end else begin
            state       <= state_next;
            shift       <= shift_next;
            count       <= count_next;
            rx_data_out <= data_next;
            rx_pulse    <= pulse_next;
            rx_err      <= err_next;
            // to_cnt counts cycles since the last byte, the byte's own cycle being 0.
            if (state_next != COLLECT)
                to_cnt <= '0;
            else if (byte_valid)
                to_cnt <= TO_W'(1);
            else if (to_cnt != TO_MAX)
                to_cnt <= to_cnt + 1'b1;
        end
    end

endmodule

// File: doc/uart_rx_hex_parser.md
Name: uart_rx_hex_parser

Overview:
Receive-side counterpart of the hex-ASCII UART transmit path. Deserialises the UART line through uart_rx, then parses a fixed-length word of ASCII hex digits ended by CR or LF into a 20-bit value. Produces a one-cycle valid pulse with the value, or a one-cycle error pulse. Sits between the board RX pin and the configuration/control logic.

Parameters:
CLK_FRE, 100, system clock in MHz (passed to uart_rx)
BAUD_RATE, 115200, line baud rate (passed to uart_rx)
DIGITS, 5, hex digits per word; output width = 4*DIGITS
TIMEOUT_CYC, 1000000, inter-byte timeout in clk cycles while a word is partial; 0 disables the timeout

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
uart_rx  input  1  serial RX pin, idle high
rx_data_out  output  4*DIGITS  last successfully parsed word, MS digit first on the line
rx_pulse  output  1  one-cycle strobe: rx_data_out updated
rx_err  output  1  one-cycle strobe: word rejected

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk. On reset: rx_data_out=0, rx_pulse=0, rx_err=0, state=IDLE, digit count=0, shift register=0, timeout counter=0.
- Byte interface from uart_rx: rx_data[7:0] and rx_data_valid; rx_data_ready is tied high. Every valid byte is consumed in its valid cycle, with no back-pressure.
- Character classes:
  - HEX: '0'-'9', 'A'-'F', 'a'-'f'; nibble = decoded value.
  - TERM: 0x0D or 0x0A.
  - OTHER: anything else.
- FSM states: IDLE (count=0), COLLECT (0<count≤DIGITS), DISCARD.
- IDLE:
  - HEX: shift<=nibble, count<=1, go to COLLECT.
  - TERM: ignored, so CRLF pairs and blank lines produce nothing.
  - OTHER: rx_err, go to DISCARD.
- COLLECT:
  - HEX with count<DIGITS: shift<={shift[4*DIGITS-5:0],nibble}, count+1.
  - HEX with count==DIGITS: overflow; rx_err, go to DISCARD.
  - TERM with count==DIGITS: rx_data_out<=shift, rx_pulse, go to IDLE.
  - TERM with count<DIGITS: short word; rx_err, go to IDLE.
  - OTHER: rx_err, go to DISCARD.
- DISCARD: drop all bytes until TERM, then go to IDLE. No pulse on that TERM. Timeout does not apply in DISCARD.
- Timeout:
  - The counter runs only in COLLECT and clears on every valid byte.
  - When it reaches TIMEOUT_CYC-1 with no byte that cycle: rx_err, count=0, go to IDLE.
  - If a byte arrives in the expiry cycle, the byte wins and the counter clears.
- Latency: rx_pulse/rx_err are registered and assert the clk cycle after the deciding byte's rx_data_valid cycle. Each strobe is exactly 1 cycle and they are never both high.
- rx_data_out changes only with rx_pulse and holds between words. Rejected words never alter it.
- Shift register and count clear on every return to IDLE.
- Reset mid-word: partial word lost, no strobe, outputs return to reset values.
- Width rules:
  - count is clog2(DIGITS+1) bits.
  - The timeout counter is sized for TIMEOUT_CYC and saturates.
  - Lowercase and uppercase decode identically.

Decomposition:
- Shared package constants: ASCII_CR=8'h0D, ASCII_LF=8'h0A, state encodings (IDLE=2'b00, COLLECT=2'b01, DISCARD=2'b10).
- The ASCII-to-nibble decode function (returns {is_hex, nibble}) is shared with the TX-side hex-to-ASCII function in the same package.
- One sub-module instance: the existing uart_rx (CLK_FRE, BAUD_RATE). Parser FSM, shift register and timeout live in this module.

Test Plan:
- "1A2B3\r" at 115200 -> one rx_pulse, rx_data_out=20'h1A2B3, rx_err never high.
- "fffff\r\n" -> rx_data_out=20'hFFFFF, exactly one rx_pulse (LF ignored in IDLE).
- "12\r" after a good 20'h1A2B3 -> one rx_err on the '\r' byte, rx_data_out stays 20'h1A2B3, no rx_pulse.
- "12G45\r00001\r" -> rx_err on 'G', "45\r" discarded silently, then rx_pulse with 20'h00001.
- "123456\r" -> rx_err on '6', no pulse; following "ABCDE\n" -> rx_data_out=20'hABCDE.
- TIMEOUT_CYC=1000: "12" then idle line -> rx_err 1000 cycles after the '2' valid cycle. Then "0C0DE\r" -> 20'h0C0DE. Reset asserted mid "AB" -> no strobe, rx_data_out=0.
